// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one uart_tx between PORTS AXI4-Stream
//            byte sources. A requester is locked in for a whole packet (until
//            tlast, or MAX_BURST beats when non-zero), and its bytes are
//            forwarded through one registered master stage so packets from
//            different sources never interleave on the serial line.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            s_axis_tdata/tvalid/  PORTS packed slave streams
//            tlast/tready
//            port_en               per-port arbitration enable
//            m_axis_tdata/tvalid/  single registered master stream to uart_tx
//            tready
//            grant                 one-hot current owner, 0 when none
//            busy                  FSM not idle or master register occupied
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            port_en,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [PORTS-1:0]            grant,
    output logic                        busy
);

    localparam int c_IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int c_CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    // Reset "last" to the highest port so that port 0 is searched first.
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(PORTS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PORTS-1:0]        r_grant;
    logic [c_IDX_W-1:0]      r_last;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_mvalid;
    logic [DATA_WIDTH-1:0]   r_mdata;

    logic [PORTS-1:0]        w_req;
    logic                    w_found;
    logic [c_IDX_W-1:0]      w_sel;
    logic [c_IDX_W-1:0]      w_cand;
    int                      w_j;

    logic                    w_gvalid;
    logic                    w_glast;
    logic [DATA_WIDTH-1:0]   w_gdata;
    logic                    w_s_ready;
    logic                    w_accept;
    logic                    w_cap;
    logic                    w_release;
    logic [PORTS-1:0]        w_tready;

    // ------------------------------------------------------------------
    // Round-robin search: first requester at (last+1), (last+2), ...
    // wrapping explicitly mod PORTS so non-power-of-2 counts work.
    // ------------------------------------------------------------------
    always_comb begin
        w_req   = s_axis_tvalid & port_en;
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        w_j     = 0;
        for (int k = 1; k <= PORTS; k++) begin
            w_j = int'(r_last) + k;
            if (w_j >= PORTS) begin
                w_j = w_j - PORTS;
            end
            w_cand = c_IDX_W'(w_j);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Granted-port stream selection (grant is one-hot or zero).
    // ------------------------------------------------------------------
    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (r_grant[i]) begin
                w_gdata = w_gdata | s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_gvalid  = |(s_axis_tvalid & r_grant);
    assign w_glast   = |(s_axis_tlast  & r_grant);
    // The master register can take a beat when empty or draining this cycle.
    assign w_s_ready = !r_mvalid || m_axis_tready;
    assign w_accept  = (r_state == ST_XFER) && w_gvalid && w_s_ready;
    assign w_cap     = (MAX_BURST != 0) && ((int'(r_cnt) + 1) == MAX_BURST);
    assign w_release = w_accept && (w_glast || w_cap);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and slave ready
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                w_tready = r_grant & {PORTS{w_s_ready}};
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, round-robin pointer and burst counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_last  <= c_LAST_RST;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_found) begin
                r_grant <= PORTS'(1) << w_sel;
                r_last  <= w_sel;
                r_cnt   <= '0;
            end
        end else if (w_accept) begin
            if (w_release) begin
                r_grant <= '0;
            end
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Master output register: load wins over drain, so a simultaneous
    // load and drain keeps tvalid high with the new byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
        end else if (w_accept) begin
            r_mvalid <= 1'b1;
            r_mdata  <= w_gdata;
        end else if (m_axis_tready) begin
            r_mvalid <= 1'b0;
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tdata  = r_mdata;
    assign m_axis_tvalid = r_mvalid;
    assign grant         = r_grant;
    assign busy          = (r_state != ST_IDLE) || r_mvalid;

endmodule
`default_nettype wire
